// File: rtl/sort_floats_seq_if.sv
// Stream interface for sort_floats_seq: upstream element feed, downstream
// sorted output, plus the batch status lines (busy, err).
interface sort_floats_seq_if #(
    parameter int FLEN = 64
);
    logic            up_valid;
    logic [FLEN-1:0] up_data;
    logic            up_ready;
    logic            down_valid;
    logic [FLEN-1:0] down_data;
    logic            down_last;
    logic            down_ready;
    logic            busy;
    logic            err;

    modport master (
        output up_valid,
        output up_data,
        input  up_ready,
        input  down_valid,
        input  down_data,
        input  down_last,
        output down_ready,
        input  busy,
        input  err
    );

    modport slave (
        input  up_valid,
        input  up_data,
        output up_ready,
        output down_valid,
        output down_data,
        output down_last,
        input  down_ready,
        output busy,
        output err
    );
endinterface

// File: rtl/sort_floats_seq.sv
// Sequential batch sorter: loads N floats, bubble-sorts them with one shared
// IEEE less-or-equal comparator, then streams them out smallest first.

module f_less_or_equal #(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);
    localparam int EW = (FLEN == 16) ? 5 : ((FLEN == 32) ? 8 : 11);
    localparam int MW = FLEN - 1 - EW;

    logic            a_sign;
    logic            b_sign;
    logic [FLEN-2:0] a_mag;
    logic [FLEN-2:0] b_mag;
    logic            a_nan;
    logic            b_nan;

    assign a_sign = a[FLEN-1];
    assign b_sign = b[FLEN-1];
    assign a_mag  = a[FLEN-2:0];
    assign b_mag  = b[FLEN-2:0];
    assign a_nan  = (&a[FLEN-2:MW]) && (|a[MW-1:0]);
    assign b_nan  = (&b[FLEN-2:MW]) && (|b[MW-1:0]);

    always_comb begin
        err = a_nan || b_nan;
        res = 1'b0;
        if (!err) begin
            // Sign-magnitude ordering; both zeros are equal regardless of sign.
            if ((a_mag == '0) && (b_mag == '0)) begin
                res = 1'b1;
            end else if (a_sign != b_sign) begin
                res = a_sign;
            end else if (!a_sign) begin
                res = (a_mag <= b_mag);
            end else begin
                res = (a_mag >= b_mag);
            end
        end
    end
endmodule

module sort_floats_seq #(
    parameter int N    = 4,
    parameter int FLEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    sort_floats_seq_if.slave    bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 2);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   pass_reg;
    logic [CW-1:0]   pass_next;
    logic [CW-1:0]   j_reg;
    logic [CW-1:0]   j_next;
    logic [CW-1:0]   j_plus;
    logic            err_sticky_reg;
    logic            err_sticky_next;

    logic [FLEN-1:0] mem_reg  [N];
    logic [FLEN-1:0] mem_next [N];

    logic            load_we;
    logic            do_swap;
    logic            cmp_res;
    logic            cmp_err;

    assign j_plus = j_reg + 1'b1;

    f_less_or_equal #(.FLEN(FLEN)) u_cmp (
        .a   (mem_reg[j_reg]),
        .b   (mem_reg[j_plus]),
        .res (cmp_res),
        .err (cmp_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= LOAD;
            cnt_reg        <= '0;
            pass_reg       <= '0;
            j_reg          <= '0;
            err_sticky_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pass_reg       <= pass_next;
            j_reg          <= j_next;
            err_sticky_reg <= err_sticky_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pass_next       = pass_reg;
        j_next          = j_reg;
        err_sticky_next = err_sticky_reg;
        load_we         = 1'b0;
        do_swap         = 1'b0;
        case (state_reg)
            LOAD: begin
                if (bus.up_valid) begin
                    load_we = 1'b1;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = SORT;
                        cnt_next   = '0;
                        pass_next  = '0;
                        j_next     = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            SORT: begin
                // A NaN compare is unordered: never swap, but flag the batch.
                do_swap         = !cmp_res && !cmp_err;
                err_sticky_next = err_sticky_reg | cmp_err;
                if (j_reg == LAST_STEP) begin
                    j_next = '0;
                    if (pass_reg == LAST_STEP) begin
                        state_next = OUT;
                        pass_next  = '0;
                    end else begin
                        pass_next = pass_reg + 1'b1;
                    end
                end else begin
                    j_next = j_plus;
                end
            end
            OUT: begin
                if (bus.down_ready) begin
                    if (cnt_reg == LAST_IDX) begin
                        state_next      = LOAD;
                        cnt_next        = '0;
                        err_sticky_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Each slot either takes the incoming element, its right neighbour
    // (swap at j == slot) or its left neighbour (swap at j+1 == slot).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            logic            take_right;
            logic            take_left;
            logic [FLEN-1:0] right_val;
            logic [FLEN-1:0] left_val;

            if (gi < N - 1) begin : g_right
                assign take_right = do_swap && (j_reg == CW'(gi));
                assign right_val  = mem_reg[gi+1];
            end else begin : g_no_right
                assign take_right = 1'b0;
                assign right_val  = '0;
            end

            if (gi > 0) begin : g_left
                assign take_left = do_swap && (j_plus == CW'(gi));
                assign left_val  = mem_reg[gi-1];
            end else begin : g_no_left
                assign take_left = 1'b0;
                assign left_val  = '0;
            end

            assign mem_next[gi] = (load_we && (cnt_reg == CW'(gi))) ? bus.up_data :
                                  take_right                        ? right_val   :
                                  take_left                         ? left_val    :
                                                                      mem_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        mem_reg <= mem_next;
    end

    assign bus.up_ready   = (state_reg == LOAD);
    assign bus.down_valid = (state_reg == OUT);
    assign bus.down_data  = mem_reg[cnt_reg];
    assign bus.down_last  = (state_reg == OUT) && (cnt_reg == LAST_IDX);
    assign bus.busy       = (state_reg != LOAD);
    assign bus.err        = (state_reg == OUT) && err_sticky_reg;
endmodule
